// File: rtl/reg4_serial_tx_if.sv
// Load handshake and serial line bundle for the register serial transmitter.
interface reg4_serial_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic [WIDTH-1:0] I;
    logic             Load;
    logic             Ready;
    logic             SerOut;
    logic             Done;

    modport master (
        output I,
        output Load,
        input  Ready,
        input  SerOut,
        input  Done
    );

    modport slave (
        input  I,
        input  Load,
        output Ready,
        output SerOut,
        output Done
    );
endinterface

// File: rtl/reg4_serial_tx.sv
// Parallel-in/serial-out framed transmitter: start bit, WIDTH data bits
// LSB-first, stop bit, each bit held for BIT_CYCLES clocks.
module reg4_serial_tx #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned BIT_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Rst,
    reg4_serial_tx_if.slave bus
);
    localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic             ser_q;
    logic             rdy_q;
    logic             done_q;
    logic             bit_end;

    assign shreg_nx   = shreg >> 1;
    assign bit_end    = (cnt == CNT_LAST);
    assign bus.SerOut = ser_q;
    assign bus.Ready  = rdy_q;
    assign bus.Done   = done_q;

    // Frame sequencer; every output is a register loaded one edge ahead.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state  <= IDLE;
            shreg  <= '0;
            cnt    <= '0;
            idx    <= '0;
            ser_q  <= 1'b1;
            rdy_q  <= 1'b1;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Load) begin
                        shreg <= bus.I;
                        cnt   <= '0;
                        state <= START;
                        ser_q <= 1'b0;
                        rdy_q <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= DATA;
                        ser_q <= shreg[0];
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt <= '0;
                        if (idx == IDX_LAST) begin
                            state <= STOP;
                            ser_q <= 1'b1;
                        end else begin
                            shreg <= shreg_nx;
                            idx   <= idx + IDX_W'(1);
                            ser_q <= shreg_nx[0];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt    <= '0;
                        state  <= IDLE;
                        ser_q  <= 1'b1;
                        rdy_q  <= 1'b1;
                        done_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    ser_q <= 1'b1;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg4_serial_tx.sv
// Scoreboard bench: per-cycle expected {SerOut,Ready,Done} queued at load time.
module tb_reg4_serial_tx;
    logic Clk;
    logic Rst;

    reg4_serial_tx_if #(.WIDTH(4)) bus0 ();
    reg4_serial_tx_if #(.WIDTH(4)) bus1 ();

    reg4_serial_tx #(.WIDTH(4), .BIT_CYCLES(2)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus0.slave)
    );

    reg4_serial_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut1 (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus1.slave)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [2:0] q0[$];
    logic [2:0] q1[$];

    localparam logic [2:0] IDLE_EXP = 3'b110;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected samples, one per cycle after the accepting edge, plus the Done cycle.
    task automatic push_frame(input int which, input logic [3:0] d, input int bc);
        logic [2:0] e[$];
        for (int c = 0; c < bc; c++) e.push_back(3'b000);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < bc; c++) e.push_back({d[k], 2'b00});
        for (int c = 0; c < bc; c++) e.push_back(3'b100);
        e.push_back(3'b111);
        foreach (e[i]) begin
            if (which == 0) q0.push_back(e[i]);
            else            q1.push_back(e[i]);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the following negedge.
    task automatic send(input int which, input logic [3:0] d);
        if (which == 0) begin
            bus0.I = d; bus0.Load = 1'b1;
            push_frame(0, d, 2);
        end else begin
            bus1.I = d; bus1.Load = 1'b1;
            push_frame(1, d, 1);
        end
        @(negedge Clk);
        bus0.Load = 1'b0;
        bus1.Load = 1'b0;
    endtask

    task automatic drain(input string tag);
        int budget;
        budget = 100;
        while ((q0.size() != 0 || q1.size() != 0) && budget > 0) begin
            @(negedge Clk);
            budget--;
        end
        check(tag, 32'(q0.size() + q1.size()), 32'd0);
        repeat (3) @(negedge Clk);
    endtask

    // Monitors sample 1 time unit after each rising edge.
    always @(posedge Clk) begin
        logic [2:0] exp0;
        logic [2:0] exp1;
        #1;
        exp0 = (q0.size() != 0) ? q0.pop_front() : IDLE_EXP;
        exp1 = (q1.size() != 0) ? q1.pop_front() : IDLE_EXP;
        check("bc2_line", 32'({bus0.SerOut, bus0.Ready, bus0.Done}), 32'(exp0));
        check("bc1_line", 32'({bus1.SerOut, bus1.Ready, bus1.Done}), 32'(exp1));
    end

    initial begin
        Rst = 1'b1;
        bus0.I = '0; bus0.Load = 1'b0;
        bus1.I = '0; bus1.Load = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        repeat (10) @(negedge Clk);

        // Single frame 1010
        send(0, 4'b1010);
        drain("frame_1010");

        // Ignored load and input change mid-frame
        send(0, 4'b1111);
        repeat (3) @(negedge Clk);
        bus0.I = 4'b0000; bus0.Load = 1'b1;
        @(negedge Clk);
        bus0.Load = 1'b0;
        drain("ignored_load");

        // Back-to-back with Load held high
        bus0.I = 4'b0011; bus0.Load = 1'b1;
        push_frame(0, 4'b0011, 2);
        repeat (13) @(negedge Clk);
        check("b2b_done_seen", 32'(bus0.Done), 32'd1);
        bus0.I = 4'b1100;
        push_frame(0, 4'b1100, 2);
        @(negedge Clk);
        bus0.Load = 1'b0;
        drain("back_to_back");

        // Asynchronous reset mid-frame
        send(0, 4'b1010);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        q0.delete();
        #1;
        check("rst_ser", 32'(bus0.SerOut), 32'd1);
        check("rst_rdy", 32'(bus0.Ready), 32'd1);
        check("rst_done", 32'(bus0.Done), 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        send(0, 4'b0101);
        drain("after_reset");

        // One-cycle bits
        send(1, 4'b0110);
        drain("bc1_frame");
        send(1, 4'b1001);
        drain("bc1_frame2");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
